// File: rtl/unloader_read_port.sv
// Memory-domain read port behind the APF data unloader: queues word reads, issues one at a time, returns data in order.
// Optional one-entry hit cache enabled with `define UNLOADER_READ_PORT_HIT_CACHE_EN.
module unloader_read_port #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_memory,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_ack,
    input  logic                  invalidate,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    input  logic                  mem_busy,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WA_W  = ADDR_WIDTH - 1;
    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HIT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WA_W-1:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [WA_W-1:0]       r_mem_addr;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_ack;
    logic                  r_overflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ret;
    logic                  w_hit;
    logic                  w_unused;
    logic [WA_W-1:0]       w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_head  = r_fifo_mem[r_rd_ptr];
    // A pop on the same edge frees a slot, so a full queue can still accept.
    assign w_push  = read_en && (!w_full || w_pop);

    assign mem_rd    = (r_state == S_ISSUE);
    assign mem_addr  = r_mem_addr;
    assign read_data = r_read_data;
    assign read_ack  = r_read_ack;
    assign overflow  = r_overflow;

`ifdef UNLOADER_READ_PORT_HIT_CACHE_EN
    logic                  r_cache_valid;
    logic [WA_W-1:0]       r_cache_addr;
    logic [DATA_WIDTH-1:0] r_cache_data;

    assign w_hit    = r_cache_valid && (w_head == r_cache_addr);
    assign w_unused = read_addr[0];

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
        end else begin
            if (w_ret) begin
                r_cache_valid <= 1'b1;
                r_cache_addr  <= r_mem_addr;
                r_cache_data  <= mem_rd_data;
            end
            // Later assignment wins: invalidate beats a same-edge load.
            if (invalidate) begin
                r_cache_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hit    = 1'b0;
    assign w_unused = ^{invalidate, read_addr[0]};
`endif

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_ret        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = w_hit ? S_HIT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    w_ret        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_HIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the queue storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk_memory) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= read_addr[ADDR_WIDTH-1:1];
        end
    end

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_mem_addr  <= '0;
            r_read_data <= '0;
            r_read_ack  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_read_ack <= w_ret || (r_state == S_HIT);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_mem_addr <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (read_en && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_ret) begin
                r_read_data <= mem_rd_data;
            end
`ifdef UNLOADER_READ_PORT_HIT_CACHE_EN
            if (r_state == S_HIT) begin
                r_read_data <= r_cache_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_unloader_read_port.sv
// Self-checking bench for unloader_read_port: directed protocol steps, then randomized traffic
// against an in-order scoreboard driven by a behavioural memory controller.
module tb_unloader_read_port;

    localparam int AW    = 28;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk_memory = 1'b0;
    logic          reset;
    logic          read_en;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          read_ack;
    logic          invalidate;
    logic          mem_rd;
    logic [AW-2:0] mem_addr;
    logic          mem_busy;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    bit force_busy   = 1'b0;
    bit rand_busy    = 1'b0;
    bit rand_lat     = 1'b0;
    bit inject_valid = 1'b0;
    bit order_chk    = 1'b0;
    int ctl_latency  = 1;
    int n_accepts    = 0;

    logic [DW-1:0] ovr_q[$];
    logic [AW-2:0] iss_q[$];
    logic [AW-2:0] exp_q[$];

    always #5 clk_memory = ~clk_memory;

    unloader_read_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_memory  (clk_memory),
        .reset       (reset),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .read_ack    (read_ack),
        .invalidate  (invalidate),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_busy    (mem_busy),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .overflow    (overflow)
    );

    function automatic logic [DW-1:0] data_fn(input logic [AW-2:0] wa);
        logic [AW-2:0] t;
        t = wa * 27'd40503;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_memory);
        #1;
    endtask

    task automatic request(input logic [AW-1:0] a);
        read_en   = 1'b1;
        read_addr = a;
        tick();
        read_en   = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int i = 0;
        while (!read_ack && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(read_ack), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Behavioural controller: acts 2 time units after each edge, after the main sequence has run.
    initial begin : ctl
        bit            pending = 1'b0;
        bit            acc_now = 1'b0;
        int            lat_cnt = 0;
        logic [AW-2:0] cur_addr = '0;
        logic [AW-2:0] acc_addr = '0;
        mem_busy     = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(posedge clk_memory);
            #2;
            mem_rd_valid = 1'b0;
            if (reset) begin
                pending = 1'b0;
                acc_now = 1'b0;
            end
            if (acc_now) begin
                pending  = 1'b1;
                cur_addr = acc_addr;
                n_accepts++;
                lat_cnt = rand_lat ? int'($urandom_range(1, 4)) : ctl_latency;
                if (order_chk) begin
                    if (iss_q.size() == 0) check("accept_unexpected", 32'd1, 32'd0);
                    else check("accept_order", 32'(acc_addr), 32'(iss_q.pop_front()));
                end
            end
            if (pending) begin
                lat_cnt--;
                if (lat_cnt <= 0) begin
                    pending      = 1'b0;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = (ovr_q.size() > 0) ? ovr_q.pop_front() : data_fn(cur_addr);
                end
            end else if (inject_valid) begin
                inject_valid = 1'b0;
                mem_rd_valid = 1'b1;
                mem_rd_data  = 16'hDEAD;
            end
            mem_busy = force_busy || (rand_busy && $urandom_range(0, 2) == 0);
            if (mem_rd) check("one_outstanding", 32'(pending), 32'd0);
            acc_now  = mem_rd && !mem_busy && !reset;
            acc_addr = mem_addr;
        end
    end

    initial begin : main
        int base;
        int stray;
        int guard;
        logic [AW-1:0] a;
        reset      = 1'b1;
        read_en    = 1'b0;
        read_addr  = '0;
        invalidate = 1'b0;
        tick();
        tick();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_read_ack", 32'(read_ack), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Single read: minimum latency path.
        base = n_accepts;
        ovr_q.push_back(16'hAABB);
        request(28'hC);
        check("t1_rd_e0", 32'(mem_rd), 32'd0);
        tick();
        check("t1_rd_e1", 32'(mem_rd), 32'd1);
        check("t1_addr_e1", 32'(mem_addr), 32'h6);
        tick();
        check("t1_rd_e2", 32'(mem_rd), 32'd0);
        check("t1_ack_e2", 32'(read_ack), 32'd0);
        tick();
        check("t1_ack_e3", 32'(read_ack), 32'd1);
        check("t1_data_e3", 32'(read_data), 32'hAABB);
        tick();
        check("t1_ack_e4", 32'(read_ack), 32'd0);
        check("t1_data_hold", 32'(read_data), 32'hAABB);
        check("t1_accepts", 32'(n_accepts - base), 32'd1);

        // Back-pressure: request held stable while the controller is busy.
        base = n_accepts;
        force_busy = 1'b1;
        ovr_q.push_back(16'hBBAA);
        request(28'h124);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_rd_held", 32'(mem_rd), 32'd1);
            check("t2_addr_held", 32'(mem_addr), 32'h92);
            tick();
        end
        check("t2_no_accept", 32'(n_accepts - base), 32'd0);
        force_busy = 1'b0;
        wait_ack("t2_ack", 10);
        check("t2_data", 32'(read_data), 32'hBBAA);
        check("t2_accepts", 32'(n_accepts - base), 32'd1);
        tick();

        // Four queued requests, controller latency 3.
        ctl_latency = 3;
        ovr_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_addr = 28'(2 * i);
            tick();
        end
        read_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("t3_ack", 20);
            check("t3_data", 32'(read_data), 32'(16'h1111 * (k + 1)));
            tick();
        end
        check("t3_overflow", 32'(overflow), 32'd0);
        ctl_latency = 1;

        // Asynchronous reset: first in ISSUE, then in WAIT followed by a stray return.
        force_busy = 1'b1;
        request(28'h50);
        tick();
        check("t5_rd_issue", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rd_drop_async", 32'(mem_rd), 32'd0);
        tick();
        reset = 1'b0;
        force_busy = 1'b0;
        ctl_latency = 8;
        request(28'h40);
        tick();
        tick();
        check("t5_in_wait", 32'(mem_rd), 32'd0);
        reset = 1'b1;
        #1;
        check("t5_rd_async", 32'(mem_rd), 32'd0);
        check("t5_data_async", 32'(read_data), 32'd0);
        tick();
        reset = 1'b0;
        inject_valid = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stray += int'(read_ack);
        end
        check("t5_no_ack", 32'(stray), 32'd0);
        check("t5_data_zero", 32'(read_data), 32'd0);
        ctl_latency = 1;

        // Overflow: one in ISSUE, four queued, sixth dropped.
        base = n_accepts;
        force_busy = 1'b1;
        read_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            read_addr = 28'(28'h100 + 2 * i);
            tick();
            if (i == 4) check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        end
        read_en = 1'b0;
        check("t4_ovf_set", 32'(overflow), 32'd1);
        force_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_ack("t4_ack", 20);
            check("t4_data", 32'(read_data), 32'(data_fn(27'(27'h80 + k))));
            tick();
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            stray += int'(read_ack);
            tick();
        end
        check("t4_no_sixth", 32'(stray), 32'd0);
        check("t4_accepts", 32'(n_accepts - base), 32'd5);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        pulse_reset();
        check("t4_ovf_cleared", 32'(overflow), 32'd0);

        // Randomized traffic against an in-order scoreboard, never exceeding the queue.
        rand_busy = 1'b1;
        rand_lat  = 1'b1;
`ifndef UNLOADER_READ_PORT_HIT_CACHE_EN
        order_chk = 1'b1;
`endif
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (read_ack) begin
                if (exp_q.size() == 0) check("r_ack_unexpected", 32'd1, 32'd0);
                else check("r_data", 32'(read_data), 32'(data_fn(exp_q.pop_front())));
            end
            if ($urandom_range(0, 2) != 0 && exp_q.size() < DEPTH) begin
                a = ($urandom_range(0, 1) == 1) ? 28'($urandom_range(0, 15)) : 28'($urandom());
                read_en   = 1'b1;
                read_addr = a;
                exp_q.push_back(a[AW-1:1]);
                if (order_chk) iss_q.push_back(a[AW-1:1]);
            end else begin
                read_en = 1'b0;
            end
            tick();
        end
        read_en = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            if (read_ack) check("r_data", 32'(read_data), 32'(data_fn(exp_q.pop_front())));
            tick();
            guard++;
        end
        check("r_drained", 32'(exp_q.size()), 32'd0);
        check("r_overflow", 32'(overflow), 32'd0);
        check("r_all_issued", 32'(iss_q.size()), 32'd0);
        rand_busy = 1'b0;
        rand_lat  = 1'b0;
        order_chk = 1'b0;
        for (int i = 0; i < 10; i++) tick();

`ifdef UNLOADER_READ_PORT_HIT_CACHE_EN
        // Hit cache: same word hits, invalidate forces a memory access.
        pulse_reset();
        ctl_latency = 1;
        ovr_q.push_back(16'hAABB);
        request(28'hC);
        wait_ack("c_miss_ack", 10);
        check("c_miss_data", 32'(read_data), 32'hAABB);
        tick();
        base = n_accepts;
        request(28'hD);
        wait_ack("c_hit_ack", 4);
        check("c_hit_data", 32'(read_data), 32'hAABB);
        check("c_hit_no_mem", 32'(n_accepts - base), 32'd0);
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        ovr_q.push_back(16'h1234);
        request(28'hC);
        wait_ack("c_inv_ack", 10);
        check("c_inv_data", 32'(read_data), 32'h1234);
        check("c_inv_mem", 32'(n_accepts - base), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
